comparator_seq: RTL
===================

# comparator_seq

Parametrised iterative magnitude comparator for WIDTH-bit operands. It examines CHUNK bits per cycle, MSB chunk first, and terminates early on the first differing chunk. It supports unsigned and two's-complement signed compares and sits behind valid/ready handshakes on both sides. It is the multi-cycle, area-lean successor to the fixed-width cascaded comparators, for datapaths wider than a single-cycle compare can close timing on.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, 4, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request strobe.
- in_ready  out  1  block can accept; registered.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- l  out  1  a > b.
- g  out  1  a == b.
- m  out  1  a < b.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge, capture a, b, is_signed, set idx=NCHUNK-1, go RUN.
- RUN:
  - Compare chunk idx of the captured operands.
  - Signed mode, top chunk only: invert bit WIDTH-1 of both operands before the compare (offset-binary).
  - Chunk differs: load l/m from the chunk result, g=0, go DONE.
  - Chunk equal and idx==0: load g=1, l=m=0, go DONE.
  - Otherwise: idx decrements.
- DONE: out_valid=1. When out_ready=1 at an edge, go IDLE.
- With out_valid=1, exactly one of l/g/m is 1. l/g/m hold their last result outside DONE.
- in_ready=0 in RUN and DONE. The block ignores a, b, is_signed and in_valid there; captured operands stay stable.
- Reset:
  - All outputs are 0 during reset, including in_ready.
  - State goes to IDLE and idx to NCHUNK-1.
  - in_ready rises at the first edge after rst deasserts.
  - Reset mid-RUN or mid-DONE discards the operation; no out_valid follows.

## Timing
- Request accepted at edge T0. out_valid rises at edge T0+j, where j = number of chunks examined, 1 ≤ j ≤ NCHUNK.
- Worst case is equal operands or a difference only in chunk 0: NCHUNK cycles.
- out_valid and l/g/m are registered and change only at edges. They hold stable while out_ready=0; back-pressure is unbounded.
- After the out handshake at edge T1, in_ready=1 from T1. The next request can be accepted at T1+1 at the earliest.
- Minimum initiation interval is j+2 cycles. There is no overlap of consecutive operations.
- No combinational path from any input to any output.

## Structure
- Shared package comparator_pkg holds:
  - State encoding localparams (IDLE/RUN/DONE).
  - Result index localparams for the l/g/m ordering.
  - A clog2 helper sizing idx as max(1, clog2(NCHUNK)) bits.
- Sub-module comparator_chunk: purely combinational, parametrised CHUNK-bit compare with outputs l/g/m. Instantiate exactly once, fed by a mux that selects chunk idx from the captured operands.
- comparator_seq contains the FSM, operand registers, idx counter, signed-MSB fix-up and output registers.

## Test plan
- WIDTH=16, CHUNK=4, unsigned, a=16'h1234, b=16'h1234, out_ready=1 → out_valid at T0+4, g=1, l=m=0.
- Unsigned a=16'h9000, b=16'h1FFF → out_valid at T0+1, l=1. Same operands with is_signed=1 → out_valid at T0+1, m=1.
- Signed a=16'hFFFF, b=16'hFFFE → out_valid at T0+4, l=1. Signed a=16'hFFFF, b=16'h0000 → out_valid at T0+1, m=1.
- Unsigned a=16'h00A5, b=16'h00A7, with out_ready held 0 for 3 cycles after out_valid:
  - out_valid=1 and m=1 stay stable, in_ready=0.
  - A new in_valid pulse with different operands is ignored.
  - After out_ready=1, in_ready returns next edge.
- Accept a=16'h0001, b=16'h0002; assert rst during the 2nd RUN cycle:
  - All outputs go 0 asynchronously; no out_valid is ever produced.
  - After release, a=16'h0003, b=16'h0003 gives g=1 at T0+4.
- Randomised sweep at WIDTH=8, CHUNK=2 and WIDTH=12, CHUNK=12 (NCHUNK=1) against a reference model for both modes, including 16'h8000/16'h7FFF-style extremes.
  - Checks: l/g/m one-hot, latency = index of first differing chunk from the top + 1.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared definitions for the iterative magnitude comparator.
package comparator_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int RES_M = 0;
  localparam int RES_G = 1;
  localparam int RES_L = 2;

  function automatic int idx_bits(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational CHUNK-bit magnitude compare: l = a>b, g = a==b, m = a<b.
module comparator_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             l,
  output logic             g,
  output logic             m
);

  assign l = a > b;
  assign g = a == b;
  assign m = a < b;

endmodule

// File: rtl/comparator_seq.sv
// Iterative MSB-first magnitude comparator with early exit.
// Signed compares flip the sign bit in the top chunk (offset binary).
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             l,
  output logic             g,
  output logic             m
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = idx_bits(NCHUNK);
  localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK-1:0] flip;
  logic             cl;
  logic             cg;
  logic             cm;
  logic             accept;
  logic             finish;
  logic [2:0]       res_q;
  logic [2:0]       res_n;
  logic             ready_n;
  logic             valid_n;

  assign accept = (state == S_IDLE) && in_ready && in_valid;
  assign finish = (state == S_RUN) && (!cg || idx == '0);

  always_comb begin
    flip = '0;
    flip[CHUNK-1] = sgn_q && (idx == TOP);
    ca = a_q[int'(idx)*CHUNK +: CHUNK] ^ flip;
    cb = b_q[int'(idx)*CHUNK +: CHUNK] ^ flip;
  end

  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a(ca),
    .b(cb),
    .l(cl),
    .g(cg),
    .m(cm)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = S_RUN;
      S_RUN:   if (finish) state_n = S_DONE;
      S_DONE:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    res_n = res_q;
    if (finish) begin
      res_n = '0;
      res_n[RES_L] = cl;
      res_n[RES_G] = cg;
      res_n[RES_M] = cm;
    end
    ready_n = (state_n == S_IDLE);
    valid_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      idx       <= TOP;
      res_q     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      res_q     <= res_n;
      in_ready  <= ready_n;
      out_valid <= valid_n;
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        sgn_q <= is_signed;
        idx   <= TOP;
      end else if (state == S_RUN && !finish) begin
        idx <= idx - 1'b1;
      end
    end
  end

  assign l = res_q[RES_L];
  assign g = res_q[RES_G];
  assign m = res_q[RES_M];

endmodule
